// File: rtl/counter_scheduler_if.sv
// Request/grant bundle between requesting control logic and the counter scheduler.
// master = requester side, slave = scheduler side.
interface counter_scheduler_if #(
    parameter int WIDTH = 4
);
    logic [3:0]         req;
    logic [4*WIDTH-1:0] tc_in;
    logic               abort;
    logic [3:0]         gnt;
    logic               busy;
    logic [WIDTH-1:0]   cnt;
    logic [3:0]         done;

    modport master (
        output req, tc_in, abort,
        input  gnt, busy, cnt, done
    );

    modport slave (
        input  req, tc_in, abort,
        output gnt, busy, cnt, done
    );
endinterface

// File: rtl/counter_scheduler.sv
// Round-robin owner of one shared up-counter across four requesters.
// Each grant counts 0..tc, then pulses done to the owner.
module counter_scheduler #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    counter_scheduler_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state, w_state_nxt;
    logic [3:0]       r_gnt, w_gnt_nxt;
    logic [3:0]       r_done, w_done_nxt;
    logic [WIDTH-1:0] r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0] r_tc, w_tc_nxt;
    logic [1:0]       r_ptr, w_ptr_nxt;
    logic [1:0]       r_owner, w_owner_nxt;

    logic             w_found;
    logic [1:0]       w_win;
    logic [1:0]       w_idx;

    // Search starts one past the last owner so every requester gets a turn.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_ptr;
        w_idx   = r_ptr;
        for (int k = 1; k <= 4; k++) begin
            w_idx = r_ptr + 2'(k);
            if (!w_found && bus.req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_done_nxt  = '0;
        w_cnt_nxt   = r_cnt;
        w_tc_nxt    = r_tc;
        w_ptr_nxt   = r_ptr;
        w_owner_nxt = r_owner;
        case (r_state)
            S_IDLE: begin
                w_gnt_nxt = '0;
                w_cnt_nxt = '0;
                if (w_found) begin
                    w_owner_nxt = w_win;
                    w_tc_nxt    = bus.tc_in[w_win*WIDTH +: WIDTH];
                    w_gnt_nxt   = 4'(1) << w_win;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                // Cancel and withdrawal both drop the run silently.
                if (bus.abort || !bus.req[r_owner]) begin
                    w_state_nxt = S_IDLE;
                    w_gnt_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_ptr_nxt   = r_owner;
                end else if (r_cnt == r_tc) begin
                    w_state_nxt = S_DONE;
                    w_gnt_nxt   = '0;
                    w_done_nxt  = r_gnt;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_gnt_nxt   = '0;
                w_cnt_nxt   = '0;
                w_ptr_nxt   = r_owner;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_gnt_nxt   = '0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_done  <= '0;
            r_cnt   <= '0;
            r_tc    <= '0;
            r_ptr   <= 2'd3;
            r_owner <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_done  <= w_done_nxt;
            r_cnt   <= w_cnt_nxt;
            r_tc    <= w_tc_nxt;
            r_ptr   <= w_ptr_nxt;
            r_owner <= w_owner_nxt;
        end
    end

    assign bus.gnt  = r_gnt;
    assign bus.done = r_done;
    assign bus.cnt  = r_cnt;
    assign bus.busy = (r_state == S_RUN) || (r_state == S_DONE);
endmodule

// File: tb/tb_counter_scheduler.sv
// Directed bench for counter_scheduler: per-cycle vector table plus
// hand sequences for async reset and round-robin rotation.
module tb_counter_scheduler;
    localparam int WIDTH = 4;
    localparam int NV    = 34;

    logic clk;
    logic rst_n;
    int   nchk;
    int   nerr;

    counter_scheduler_if #(.WIDTH(WIDTH)) bus ();

    counter_scheduler #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [3:0]  req;
        logic [15:0] tc;
        logic        abort;
        logic [3:0]  gnt;
        logic [3:0]  done;
        logic [3:0]  cnt;
        logic        busy;
    } vec_t;

    vec_t vt [NV];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic [3:0] req, logic [15:0] tc, logic abort,
                                logic [3:0] gnt, logic [3:0] done, logic [3:0] cnt,
                                logic busy);
        vec_t v;
        v.req = req; v.tc = tc; v.abort = abort;
        v.gnt = gnt; v.done = done; v.cnt = cnt; v.busy = busy;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, got, exp);
        end
    endtask

    task automatic chk_out(input int idx, input logic [3:0] g, input logic [3:0] d,
                           input logic [3:0] c, input logic b);
        chk("gnt",  idx, 32'(bus.gnt),  32'(g));
        chk("done", idx, 32'(bus.done), 32'(d));
        chk("cnt",  idx, 32'(bus.cnt),  32'(c));
        chk("busy", idx, 32'(bus.busy), 32'(b));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nchk = 0;
        nerr = 0;
        //             req   tc        ab  gnt   done  cnt  busy
        vt[0]  = mk(4'h1, 16'h0003, 0, 4'h1, 4'h0, 4'd0, 1);
        vt[1]  = mk(4'h1, 16'h0003, 0, 4'h1, 4'h0, 4'd1, 1);
        vt[2]  = mk(4'h1, 16'h0003, 0, 4'h1, 4'h0, 4'd2, 1);
        vt[3]  = mk(4'h1, 16'h0003, 0, 4'h1, 4'h0, 4'd3, 1);
        vt[4]  = mk(4'h1, 16'h0003, 0, 4'h0, 4'h1, 4'd3, 1);
        vt[5]  = mk(4'h0, 16'h0003, 0, 4'h0, 4'h0, 4'd0, 0);
        vt[6]  = mk(4'h0, 16'h0000, 0, 4'h0, 4'h0, 4'd0, 0);
        // zero terminal count on requester 2
        vt[7]  = mk(4'h4, 16'h0000, 0, 4'h4, 4'h0, 4'd0, 1);
        vt[8]  = mk(4'h4, 16'h0000, 0, 4'h0, 4'h4, 4'd0, 1);
        vt[9]  = mk(4'h0, 16'h0000, 0, 4'h0, 4'h0, 4'd0, 0);
        // tc_in changes mid-run are ignored
        vt[10] = mk(4'h8, 16'h5000, 0, 4'h8, 4'h0, 4'd0, 1);
        vt[11] = mk(4'h8, 16'h5000, 0, 4'h8, 4'h0, 4'd1, 1);
        vt[12] = mk(4'h8, 16'h2000, 0, 4'h8, 4'h0, 4'd2, 1);
        vt[13] = mk(4'h8, 16'h2000, 0, 4'h8, 4'h0, 4'd3, 1);
        vt[14] = mk(4'h8, 16'h2000, 0, 4'h8, 4'h0, 4'd4, 1);
        vt[15] = mk(4'h8, 16'h2000, 0, 4'h8, 4'h0, 4'd5, 1);
        vt[16] = mk(4'h8, 16'h2000, 0, 4'h0, 4'h8, 4'd5, 1);
        vt[17] = mk(4'h8, 16'h5000, 0, 4'h0, 4'h0, 4'd0, 0);
        // withdrawal at cnt=3
        vt[18] = mk(4'h8, 16'h5000, 0, 4'h8, 4'h0, 4'd0, 1);
        vt[19] = mk(4'h8, 16'h5000, 0, 4'h8, 4'h0, 4'd1, 1);
        vt[20] = mk(4'h8, 16'h5000, 0, 4'h8, 4'h0, 4'd2, 1);
        vt[21] = mk(4'h8, 16'h5000, 0, 4'h8, 4'h0, 4'd3, 1);
        vt[22] = mk(4'h0, 16'h5000, 0, 4'h0, 4'h0, 4'd0, 0);
        vt[23] = mk(4'h0, 16'h0090, 0, 4'h0, 4'h0, 4'd0, 0);
        // abort at cnt=4, then requester 0 wins over 1
        vt[24] = mk(4'h2, 16'h0090, 0, 4'h2, 4'h0, 4'd0, 1);
        vt[25] = mk(4'h2, 16'h0090, 0, 4'h2, 4'h0, 4'd1, 1);
        vt[26] = mk(4'h2, 16'h0090, 0, 4'h2, 4'h0, 4'd2, 1);
        vt[27] = mk(4'h2, 16'h0090, 0, 4'h2, 4'h0, 4'd3, 1);
        vt[28] = mk(4'h2, 16'h0090, 0, 4'h2, 4'h0, 4'd4, 1);
        vt[29] = mk(4'h3, 16'h0090, 1, 4'h0, 4'h0, 4'd0, 0);
        vt[30] = mk(4'h3, 16'h0090, 0, 4'h1, 4'h0, 4'd0, 1);
        vt[31] = mk(4'h3, 16'h0090, 0, 4'h0, 4'h1, 4'd0, 1);
        vt[32] = mk(4'h0, 16'h0090, 0, 4'h0, 4'h0, 4'd0, 0);
        vt[33] = mk(4'h0, 16'h0090, 1, 4'h0, 4'h0, 4'd0, 0);

        bus.req   = '0;
        bus.tc_in = '0;
        bus.abort = 1'b0;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_out(-1, 4'h0, 4'h0, 4'd0, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            bus.req   = vt[i].req;
            bus.tc_in = vt[i].tc;
            bus.abort = vt[i].abort;
            @(posedge clk);
            #1;
            chk_out(i, vt[i].gnt, vt[i].done, vt[i].cnt, vt[i].busy);
        end

        // Async reset mid-run: outputs clear before any clock edge.
        bus.abort = 1'b0;
        bus.req   = 4'h1;
        bus.tc_in = 16'h0005;
        repeat (3) @(posedge clk);
        #1;
        chk_out(100, 4'h1, 4'h0, 4'd2, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out(101, 4'h0, 4'h0, 4'd0, 1'b0);
        #2;
        rst_n     = 1'b1;
        bus.req   = 4'hF;
        bus.tc_in = 16'h1111;

        // All requesting with tc=1: grants rotate 0,1,2,3,0.
        for (int k = 0; k < 5; k++) begin
            logic [3:0] oh;
            oh = 4'(1) << (k % 4);
            @(posedge clk); #1;
            chk_out(200 + 4*k, oh, 4'h0, 4'd0, 1'b1);
            @(posedge clk); #1;
            chk_out(201 + 4*k, oh, 4'h0, 4'd1, 1'b1);
            @(posedge clk); #1;
            chk_out(202 + 4*k, 4'h0, oh, 4'd1, 1'b1);
            @(posedge clk); #1;
            chk_out(203 + 4*k, 4'h0, 4'h0, 4'd0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule

// File: doc/counter_scheduler.md
# counter_scheduler

Round-robin scheduler that shares one WIDTH-bit up-counter between four requesters. Each requester asks for a count run to its own terminal value. The block grants the counter to one requester at a time, runs the count from 0 to that terminal value, then pulses done to the owner. It sits between the requesting control logic and the counter datapath and is the only writer of the count.

## Interface
- WIDTH, 4, count and terminal-value width
- clk  input  1  single clock, all state changes on posedge
- rst_n  input  1  reset, asynchronous, active-low
- req  input  4  request per requester, level; held high until done or withdrawn
- tc_in  input  4*WIDTH  terminal count per requester; requester i uses bits [i*WIDTH +: WIDTH]
- abort  input  1  cancel current run, synchronous
- gnt  output  4  one-hot grant, owner of the counter
- busy  output  1  high in RUN and DONE
- cnt  output  WIDTH  current count value
- done  output  4  one-cycle completion pulse to the owner

## Operation
- Reset (rst_n low, asynchronous) forces:
  - state = IDLE
  - gnt = 0, done = 0, cnt = 0, busy = 0
  - round-robin pointer = 3, so requester 0 has first priority
- States: IDLE, RUN, DONE.
- IDLE:
  - gnt = 0, cnt = 0.
  - If any req bit is high, pick the winner by searching from pointer+1 upward, modulo 4.
  - Latch the winner's tc_in slice into an internal tc register.
  - Set gnt to the winner's one-hot bit, cnt = 0, and go to RUN.
- RUN checks, in priority order:
  1. abort high: go to IDLE. No done pulse. Pointer is set to the owner.
  2. req[owner] low (withdrawal): same as abort.
  3. cnt == tc: go to DONE.
  4. Otherwise cnt increments by 1.
- DONE:
  - done[owner] = 1 and gnt = 0; cnt holds at tc.
  - Pointer is set to the owner.
  - Next state is unconditionally IDLE.
- tc is captured only at grant. Changes to tc_in during RUN are ignored.
- cnt never wraps, because it stops at tc and tc ≤ 2^WIDTH−1.
- tc = 0 is legal: RUN lasts 1 cycle with cnt = 0, then DONE.
- abort in IDLE or DONE has no effect.
- Requests that arrive while busy wait. They are arbitrated in the next IDLE cycle, using the updated pointer.
- rst_n assertion mid-run returns to reset values immediately, with no done pulse.

## Timing
- Grant latency: req sampled high in IDLE at edge N gives gnt high after edge N, with cnt = 0.
- The grant is held for exactly tc+1 cycles. cnt shows 0, 1, …, tc.
- done pulse: one cycle, immediately after the grant falls. gnt and done are never high at the same time.
- Minimum spacing between grants: DONE (1 cycle) plus IDLE (1 cycle). Back-to-back runs start 2 cycles after the previous grant falls.
- Abort or withdrawal seen at edge M clears gnt after edge M. cnt = 0 from that cycle on.
- No combinational path from any input to any output. All outputs are registered or decoded from state registers.
- The owner must hold req high through DONE. Dropping req in the DONE cycle is ignored.

## Test plan
- Reset then single run: rst_n low → all outputs 0. Release, req=0001, tc0=3 → gnt=0001 for 4 cycles with cnt 0,1,2,3, then done=0001 for 1 cycle, then IDLE with cnt=0.
- Round-robin fairness: req=1111 held continuously, all tc=1 → grant order 0,1,2,3,0. Each gnt lasts 2 cycles and is followed by done on the same bit.
- Zero terminal count: req=0100, tc2=0 → gnt=0100 for 1 cycle with cnt=0, then done=0100.
- Abort mid-run: req=0010, tc1=9, abort pulsed when cnt=4 → gnt=0 and cnt=0 next cycle, no done pulse. With req=0011 still high, requester 0 is granted next, because the pointer is now 1.
- Withdrawal and tc change: req=1000, tc3=5; change tc3 to 2 at cnt=1 → the run still reaches 5. Repeat the run and drop req[3] at cnt=3 → returns to IDLE with no done pulse.
- Async reset mid-run: rst_n low while cnt=2 and gnt=0001 → gnt, cnt, done and busy are 0 without waiting for a clock edge. After release, requester 0 has first priority.
